step_dir_pulse_gen: RTL and testbench
=====================================

// Module: step_dir_pulse_gen
// PURPOSE
//  Initiator side of the STEP/DIR interface: turns a move command (direction,
//  step count, step period) into timed STEP pulses and a DIR level. It drives the
//  step/dir pins that the stepper driver samples when it is under external control.
//  Guarantees minimum STEP high time, DIR setup before the first edge, and constant
//  edge-to-edge period. Supports abort.
// PARAMETERS
//  CNT_W      16  width of step count / steps_left
//  PER_W      16  width of step period, in clk cycles
//  PULSE_W     4  STEP high time in cycles (>=1)
//  DIR_SETUP   2  cycles DIR must be stable before a STEP rising edge (>=1)
// PORTS
//  clk         in   1      single clock; all logic rising-edge
//  rst         in   1      synchronous, active-high reset
//  cmd_valid   in   1      move command offered
//  cmd_ready   out  1      =1 only in IDLE (combinational from state)
//  cmd_dir     in   1      requested direction (1 = CW)
//  cmd_steps   in   CNT_W  number of steps; 0 is legal
//  cmd_period  in   PER_W  rising-edge-to-rising-edge cycles
//  abort       in   1      stop after the current pulse
//  step_out    out  1      STEP pin, registered
//  dir_out     out  1      DIR pin, registered
//  busy        out  1      high in SETUP/HIGH/LOW
//  done        out  1      1-cycle pulse when a command completes or aborts
//  steps_left  out  CNT_W  steps still to issue
// BEHAVIOUR
//  Reset values: step_out=0, dir_out=0, busy=0, done=0, steps_left=0, state=IDLE
//   (so cmd_ready=1). Reset mid-move takes effect at the next edge: STEP is cut
//   short, no done pulse.
//  Accept: cmd_valid&&cmd_ready in cycle N. Latch dir, steps, and
//   eff_period=max(cmd_period, PULSE_W+1). steps_left<=cmd_steps.
//  FSM: IDLE -> SETUP | HIGH | DONE; SETUP -> HIGH; HIGH -> LOW;
//   LOW -> HIGH | DONE; DONE -> IDLE.
//  cmd_steps==0: IDLE->DONE; done=1 at N+1; no STEP, DIR unchanged.
//  DIR change (cmd_dir!=dir_out): dir_out updates at N+1. Stay in SETUP for
//   DIR_SETUP cycles. First step_out=1 at N+1+DIR_SETUP.
//  DIR unchanged: step_out=1 at N+1 (no SETUP).
//  HIGH: step_out=1 for exactly PULSE_W cycles. steps_left decrements on entering
//   HIGH.
//  LOW: step_out=0 for eff_period-PULSE_W cycles. Then HIGH if steps_left!=0,
//   else DONE.
//  DONE: done=1 and busy=0 for one cycle, then IDLE. A new command can be
//   accepted the cycle after done. The last step gets its full low time.
//  abort: sampled in every state. In SETUP or LOW, go to DONE next cycle.
//   In HIGH, finish the full PULSE_W high time, then DONE.
//   steps_left holds its value (reports steps not issued).
//   abort in IDLE/DONE is ignored.
//  dir_out changes only in the cycle after accept, never while busy.
//  Counters saturate-free: period counter loads eff_period-1 and counts down.
//   Width of eff_period is PER_W; PULSE_W+1 must fit in PER_W (elaboration check).
// STRUCTURE
//  stepper_defs.vh (shared with the driver): state encodings ST_IDLE/ST_SETUP/
//   ST_HIGH/ST_LOW/ST_DONE, DIR_CW=1/DIR_CCW=0, default PULSE_W/DIR_SETUP.
//  One sub-module: step_timer: loadable PER_W down-counter (load, value, en)
//   with a registered zero flag. It is reused for SETUP, HIGH and LOW phases.
//  Top holds the FSM, the command latch and steps_left.
// TESTING
//  1. Reset, then cmd dir=1 (dir_out=0), steps=3, period=10, PULSE_W=4.
//     -> dir_out=1 at N+1, rises at N+3, N+13, N+23, each 4 cycles wide.
//     -> done at N+33, steps_left=0.
//  2. Same dir, steps=2, period=2 -> eff_period=5.
//     -> step rises at N+1 and N+6; done at N+11.
//  3. steps=0 -> no STEP edge, done at N+1, cmd_ready=1 at N+2.
//  4. steps=10, period=8; abort one cycle after the 3rd rising edge.
//     -> 3rd pulse still 4 cycles high, no 4th edge, done 1 cycle later,
//        steps_left=7.
//  5. cmd_valid held high during busy.
//     -> cmd_ready=0, not accepted until the cycle after done.
//     -> DIR stable for the whole move.
//  6. rst asserted mid-HIGH -> step_out=0, busy=0, done=0 next cycle.
//     -> cmd_ready=1; next command behaves as in test 1.

Source files
------------

// File: rtl/step_dir_pulse_gen_pkg.sv
// Shared STEP/DIR definitions: FSM states,
// direction levels and default timing.
package step_dir_pulse_gen_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_HIGH  = 3'd2,
        ST_LOW   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic DIR_CW  = 1'b1;
    localparam logic DIR_CCW = 1'b0;

    localparam int DEF_PULSE_W   = 4;
    localparam int DEF_DIR_SETUP = 2;

endpackage

// File: rtl/step_dir_pulse_gen_timer.sv
// Loadable down-counter shared by the
// SETUP, HIGH and LOW phases.
module step_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] count;
    logic [W-1:0] count_nx;

    // next count: load wins, else count down to 0
    always_comb begin
        count_nx = count;
        if (load) begin
            count_nx = value;
        end else if (en && count != '0) begin
            count_nx = count - W'(1);
        end
    end

    // count register and registered zero flag
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            zero  <= 1'b1;
        end else begin
            count <= count_nx;
            zero  <= (count_nx == '0);
        end
    end

endmodule

// File: rtl/step_dir_pulse_gen.sv
// STEP/DIR initiator: turns a move command
// into timed STEP pulses and a DIR level.
module step_dir_pulse_gen
    import step_dir_pulse_gen_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int PER_W     = 16,
    parameter int PULSE_W   = DEF_PULSE_W,
    parameter int DIR_SETUP = DEF_DIR_SETUP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic [PER_W-1:0] cmd_period,
    input  logic             abort,
    output logic             step_out,
    output logic             dir_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] steps_left
);

    if (PULSE_W < 1 || DIR_SETUP < 1) begin : g_chk_min
        $error("PULSE_W and DIR_SETUP must be >= 1");
    end
    if (PULSE_W + 1 >= (2 ** PER_W)) begin : g_chk_w
        $error("PULSE_W+1 does not fit in PER_W");
    end

    localparam logic [PER_W-1:0] PW_M1 =
        PER_W'(PULSE_W - 1);
    localparam logic [PER_W-1:0] SU_M1 =
        PER_W'(DIR_SETUP - 1);
    localparam logic [PER_W-1:0] MIN_PER =
        PER_W'(PULSE_W + 1);

    state_t           state;
    state_t           state_nx;
    logic [PER_W-1:0] per_q;
    logic [PER_W-1:0] eff_per;
    logic             abort_q;
    logic             accept;
    logic             tmr_load;
    logic [PER_W-1:0] tmr_val;
    logic             tmr_en;
    logic             tmr_zero;

    assign cmd_ready = (state == ST_IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign eff_per   = (cmd_period < MIN_PER) ?
                       MIN_PER : cmd_period;
    assign tmr_en    = (state != ST_IDLE) &&
                       (state != ST_DONE);

    step_timer #(
        .W (PER_W)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (tmr_load),
        .value (tmr_val),
        .en    (tmr_en),
        .zero  (tmr_zero)
    );

    // next state and phase-timer load
    always_comb begin
        state_nx = state;
        tmr_load = 1'b0;
        tmr_val  = PW_M1;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (cmd_steps == '0) begin
                        state_nx = ST_DONE;
                    end else if (cmd_dir != dir_out) begin
                        state_nx = ST_SETUP;
                        tmr_load = 1'b1;
                        tmr_val  = SU_M1;
                    end else begin
                        state_nx = ST_HIGH;
                        tmr_load = 1'b1;
                    end
                end
            end
            ST_SETUP: begin
                if (abort) begin
                    state_nx = ST_DONE;
                end else if (tmr_zero) begin
                    state_nx = ST_HIGH;
                    tmr_load = 1'b1;
                end
            end
            ST_HIGH: begin
                if (tmr_zero) begin
                    if (abort || abort_q) begin
                        state_nx = ST_DONE;
                    end else begin
                        state_nx = ST_LOW;
                        tmr_load = 1'b1;
                        tmr_val  = per_q - MIN_PER;
                    end
                end
            end
            ST_LOW: begin
                if (abort) begin
                    state_nx = ST_DONE;
                end else if (tmr_zero) begin
                    if (steps_left != '0) begin
                        state_nx = ST_HIGH;
                        tmr_load = 1'b1;
                    end else begin
                        state_nx = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // state, pins, command latch, step count
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            step_out   <= 1'b0;
            dir_out    <= DIR_CCW;
            busy       <= 1'b0;
            done       <= 1'b0;
            steps_left <= '0;
            per_q      <= MIN_PER;
            abort_q    <= 1'b0;
        end else begin
            state    <= state_nx;
            step_out <= (state_nx == ST_HIGH);
            busy     <= (state_nx == ST_SETUP) ||
                        (state_nx == ST_HIGH) ||
                        (state_nx == ST_LOW);
            done     <= (state_nx == ST_DONE);
            abort_q  <= (state == ST_HIGH) &&
                        (abort || abort_q);
            if (accept) begin
                per_q <= eff_per;
                if (cmd_steps != '0) begin
                    dir_out <= cmd_dir;
                end
                if (state_nx == ST_HIGH) begin
                    steps_left <= cmd_steps - CNT_W'(1);
                end else begin
                    steps_left <= cmd_steps;
                end
            end else if (state != ST_HIGH &&
                         state_nx == ST_HIGH) begin
                steps_left <= steps_left - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_step_dir_pulse_gen.sv
// Directed bench for step_dir_pulse_gen:
// traces pins per cycle against pulse masks.
module tb_step_dir_pulse_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_dir = 1'b0;
    logic [15:0] cmd_steps = '0;
    logic [15:0] cmd_period = '0;
    logic        abort = 1'b0;
    logic        step_out;
    logic        dir_out;
    logic        busy;
    logic        done;
    logic [15:0] steps_left;

    int checks = 0;
    int errors = 0;

    logic [63:0] tr_st, tr_dn, tr_dr, tr_bz, tr_rd;
    logic [63:0] exp_v;

    step_dir_pulse_gen #(
        .CNT_W     (16),
        .PER_W     (16),
        .PULSE_W   (4),
        .DIR_SETUP (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_dir    (cmd_dir),
        .cmd_steps  (cmd_steps),
        .cmd_period (cmd_period),
        .abort      (abort),
        .step_out   (step_out),
        .dir_out    (dir_out),
        .busy       (busy),
        .done       (done),
        .steps_left (steps_left)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout global");
        $fatal(1, "bench did not finish");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag,
                         input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h",
                   tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pulses(
        input int first, input int per,
        input int cnt, input int w);
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < cnt; i++)
            for (int j = 0; j < w; j++)
                m[first + i * per + j] = 1'b1;
        return m;
    endfunction

    function automatic logic [63:0] span(
        input int a, input int b);
        logic [63:0] m;
        m = '0;
        for (int i = a; i <= b; i++)
            m[i] = 1'b1;
        return m;
    endfunction

    task automatic run_cmd(input logic d,
                           input logic [15:0] s,
                           input logic [15:0] p,
                           input bit hold,
                           input int ab,
                           input int n);
        check("accept_ready", 64'(cmd_ready), 64'd1);
        cmd_valid  = 1'b1;
        cmd_dir    = d;
        cmd_steps  = s;
        cmd_period = p;
        tr_st = '0; tr_dn = '0; tr_dr = '0;
        tr_bz = '0; tr_rd = '0;
        for (int k = 1; k <= n; k++) begin
            tick();
            cmd_valid = hold;
            abort     = (k == ab);
            tr_st[k]  = step_out;
            tr_dn[k]  = done;
            tr_dr[k]  = dir_out;
            tr_bz[k]  = busy;
            tr_rd[k]  = cmd_ready;
        end
        cmd_valid = 1'b0;
        abort     = 1'b0;
    endtask

    task automatic wait_done(input string tag,
                             input int bound);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check(tag, 64'(seen), 64'd1);
        tick();
    endtask

    task automatic test_one(input string tag);
        run_cmd(1'b1, 16'd3, 16'd10, 1'b0, 0, 36);
        check({tag, "_step"}, tr_st, pulses(3, 10, 3, 4));
        check({tag, "_done"}, tr_dn, pulses(33, 1, 1, 1));
        check({tag, "_dir"}, tr_dr, span(1, 36));
        check({tag, "_busy"}, tr_bz, span(1, 32));
        check({tag, "_left"}, 64'(steps_left), 64'd0);
    endtask

    initial begin
        repeat (3) tick();
        check("rst_step", 64'(step_out), 64'd0);
        check("rst_dir", 64'(dir_out), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_left", 64'(steps_left), 64'd0);
        check("rst_ready", 64'(cmd_ready), 64'd1);
        rst = 1'b0;
        tick();

        test_one("t1");

        run_cmd(1'b1, 16'd2, 16'd2, 1'b0, 0, 14);
        check("t2_step", tr_st, pulses(1, 5, 2, 4));
        check("t2_done", tr_dn, pulses(11, 1, 1, 1));
        check("t2_left", 64'(steps_left), 64'd0);

        run_cmd(1'b0, 16'd0, 16'd9, 1'b0, 0, 3);
        check("t3_step", tr_st, 64'd0);
        check("t3_done", tr_dn, pulses(1, 1, 1, 1));
        check("t3_dir", tr_dr, span(1, 3));
        check("t3_ready", tr_rd, span(2, 3));

        run_cmd(1'b1, 16'd10, 16'd8, 1'b0, 18, 24);
        check("t4_step", tr_st, pulses(1, 8, 3, 4));
        check("t4_done", tr_dn, pulses(21, 1, 1, 1));
        check("t4_busy", tr_bz, span(1, 20));
        check("t4_left", 64'(steps_left), 64'd7);

        run_cmd(1'b0, 16'd2, 16'd6, 1'b1, 0, 18);
        exp_v = pulses(3, 6, 2, 4) | span(17, 18);
        check("t5_step", tr_st, exp_v);
        check("t5_done", tr_dn, pulses(15, 1, 1, 1));
        check("t5_ready", tr_rd, pulses(16, 1, 1, 1));
        check("t5_dir", tr_dr, 64'd0);
        wait_done("t5_second_done", 30);
        check("t5_dir_end", 64'(dir_out), 64'd0);

        run_cmd(1'b1, 16'd3, 16'd10, 1'b0, 0, 4);
        check("t6_pre_step", tr_st, span(3, 4));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_step", 64'(step_out), 64'd0);
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_done", 64'(done), 64'd0);
        check("t6_dir", 64'(dir_out), 64'd0);
        check("t6_ready", 64'(cmd_ready), 64'd1);
        test_one("t6r");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
